serpario_chain: RTL and testbench

Parametrised controller for daisy-chained serial-in/parallel-out (74HC595-class) and parallel-in/serial-out (74HC165-class) expander registers on the misc I/O board. It replaces the fixed-width serial/parallel I/O engine with a WIDTH-bit chain, a programmable shift-clock divider, optional autonomous refresh and an optional input change interrupt. It sits between the platform's register-slave logic and the `serpario*` pads, in the PLL output clock domain.

---
 rtl/serpario_pkg.sv | 26 ++
 rtl/serpario_chain_tick.sv | 44 ++++
 rtl/serpario_chain.sv | 188 ++++++++++++++++++
 tb/tb_serpario_chain.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/serpario_pkg.sv
// serpario_pkg
//   Shared definitions for the serpario_chain expander controller.
//   - state_e     : controller FSM states
//   - txn_cycles(): clk_i cycles from start acceptance to the done_o cycle,
//                   as a function of chain width and shift-clock divider
package serpario_pkg;

    typedef enum logic [2:0] {
        INIT_LO,
        INIT_HI,
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        STORE_LO,
        STORE_HI,
        DONE
    } state_e;

    function automatic int unsigned txn_cycles(input int unsigned width,
                                               input int unsigned clk_div);
        return 2 * clk_div * (width + 1) + 1;
    endfunction

    localparam int unsigned TXN_CYCLES_DEFAULT = txn_cycles(16, 4);

endpackage

// File: rtl/serpario_chain_tick.sv
// serpario_tick
//   Shift-clock phase timer. Down-counts CLK_DIV cycles and raises strobe_o
//   in the last cycle of each phase. Restarts whenever the FSM enters a new
//   state.
//   Ports:
//     clk_i     : clock
//     reset     : synchronous, active-high
//     restart_i : FSM changes state at the coming edge
//     strobe_o  : current cycle is the last of the phase
module serpario_tick #(
    parameter int CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic reset,
    input  logic restart_i,
    output logic strobe_o
);

    localparam int CW = $clog2(CLK_DIV + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (restart_i) begin
            cnt_d = CW'(CLK_DIV - 1);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Reset value is one above the reload value so the first cycle after
    // reset release counts as the first cycle of INIT_LO.
    always_ff @(posedge clk_i) begin
        if (reset) begin
            cnt_q <= CW'(CLK_DIV);
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign strobe_o = (cnt_q == '0);

endmodule

// File: rtl/serpario_chain.sv
// serpario_chain
//   Controller for daisy-chained '595 (SIPO) output and '165 (PISO) input
//   expanders sharing one shift clock and one store/load line.
//   Optional change interrupt: define SERPARIO_CHANGE_IRQ_EN.
//   Ports:
//     clk_i, reset          : clock, synchronous active-high reset
//     out_data_i, start_i   : output image, transaction request (IDLE only)
//     busy_o, done_o        : INIT/transaction in progress, end pulse
//     in_data_o             : input image, updated on done_o
//     irq_o, irq_ack_i      : input change interrupt and acknowledge
//     ser_in_i, ser_out_o   : '165 Q_H, '595 SER
//     sh_clk_o, store_o     : shift clock, '165 SH/LD_n + '595 RCLK
//     out_en_o              : '595 OE_n
//
//   state    | meaning
//   INIT_LO  | store low after reset, preloads the '165 chain
//   INIT_HI  | store high, chain settles before first use
//   IDLE     | waiting for start_i or refresh expiry
//   SHIFT_LO | shift clock low, SER shows current bit, Q_H sampled at end
//   SHIFT_HI | shift clock high, both chains shift
//   STORE_LO | store low, '165 parallel load
//   STORE_HI | store high, rising edge latches '595 outputs
//   DONE     | in_data_o updated, done_o pulse
module serpario_chain
    import serpario_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int CLK_DIV = 4,
    parameter int REFRESH = 0
) (
    input  logic             clk_i,
    input  logic             reset,
    input  logic [WIDTH-1:0] out_data_i,
    input  logic             start_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] in_data_o,
    output logic             irq_o,
    input  logic             irq_ack_i,
    input  logic             ser_in_i,
    output logic             ser_out_o,
    output logic             sh_clk_o,
    output logic             store_o,
    output logic             out_en_o
);

    localparam int BW = $clog2(WIDTH + 1);
    localparam int RW = (REFRESH > 0) ? $clog2(REFRESH + 1) : 1;
    localparam logic [RW-1:0] REF_LOAD = RW'(REFRESH);

    state_e            state_q, state_d;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0]  shadow_q, shadow_d;
    logic [WIDTH-1:0]  cap_q, cap_d;
    logic [RW-1:0]     ref_cnt_q, ref_cnt_d;
    logic              refresh_hit;
    logic              tick;
    logic              busy_q, done_q, sh_clk_q, ser_out_q, store_q, out_en_q;
    logic [WIDTH-1:0]  in_data_q;

    serpario_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk_i     (clk_i),
        .reset     (reset),
        .restart_i (state_d != state_q),
        .strobe_o  (tick)
    );

    // Refresh only runs once the outputs are enabled; reloads outside IDLE
    // and on any start.
    always_comb begin
        ref_cnt_d   = REF_LOAD;
        refresh_hit = 1'b0;
        if (REFRESH != 0 && state_q == IDLE && !out_en_q) begin
            if (ref_cnt_q == RW'(1)) begin
                refresh_hit = 1'b1;
            end else if (!start_i) begin
                ref_cnt_d = ref_cnt_q - 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shadow_d  = shadow_q;
        cap_d     = cap_q;
        case (state_q)
            INIT_LO:  if (tick) state_d = INIT_HI;
            INIT_HI:  if (tick) state_d = IDLE;
            IDLE: begin
                if (start_i || refresh_hit) begin
                    state_d   = SHIFT_LO;
                    bit_cnt_d = BW'(WIDTH);
                    if (start_i) shadow_d = out_data_i;
                end
            end
            SHIFT_LO: begin
                if (tick) begin
                    cap_d   = {cap_q[WIDTH-2:0], ser_in_i};
                    state_d = SHIFT_HI;
                end
            end
            SHIFT_HI: begin
                if (tick) begin
                    // Rotate so the shadow is intact again for a refresh.
                    shadow_d  = {shadow_q[WIDTH-2:0], shadow_q[WIDTH-1]};
                    bit_cnt_d = bit_cnt_q - 1'b1;
                    state_d   = (bit_cnt_q == BW'(1)) ? STORE_LO : SHIFT_LO;
                end
            end
            STORE_LO: if (tick) state_d = STORE_HI;
            STORE_HI: if (tick) state_d = DONE;
            DONE:     state_d = IDLE;
            default:  state_d = INIT_LO;
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk_i) begin
        if (reset) begin
            state_q   <= INIT_LO;
            bit_cnt_q <= '0;
            shadow_q  <= '0;
            cap_q     <= '0;
            ref_cnt_q <= REF_LOAD;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            in_data_q <= '0;
            sh_clk_q  <= 1'b0;
            ser_out_q <= 1'b0;
            store_q   <= 1'b1;
            out_en_q  <= 1'b1;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shadow_q  <= shadow_d;
            cap_q     <= cap_d;
            ref_cnt_q <= ref_cnt_d;
            busy_q    <= (state_d != IDLE);
            done_q    <= (state_d == DONE);
            sh_clk_q  <= (state_d == SHIFT_HI);
            store_q   <= !(state_d == INIT_LO || state_d == STORE_LO);
            if (state_d == SHIFT_LO) ser_out_q <= shadow_d[WIDTH-1];
            if (state_d == DONE) begin
                in_data_q <= cap_q;
                out_en_q  <= 1'b0;
            end
        end
    end

`ifdef SERPARIO_CHANGE_IRQ_EN
    logic irq_q, irq_d;

    // out_en_q is still 1 while entering the first DONE, which masks the
    // meaningless comparison against the reset value of in_data_q.
    always_comb begin
        irq_d = irq_q;
        if (state_d == DONE && !out_en_q && cap_q != in_data_q) begin
            irq_d = 1'b1;
        end else if (irq_ack_i) begin
            irq_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq_o = irq_q;
`else
    logic unused_irq_ack;
    assign unused_irq_ack = irq_ack_i;
    assign irq_o          = 1'b0;
`endif

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign in_data_o = in_data_q;
    assign sh_clk_o  = sh_clk_q;
    assign ser_out_o = ser_out_q;
    assign store_o   = store_q;
    assign out_en_o  = out_en_q;

endmodule

// File: tb/tb_serpario_chain.sv
// Directed bench for serpario_chain: WIDTH=16, CLK_DIV=2, REFRESH=200,
// with a behavioural '165 chain on the input side.
module tb_serpario_chain;

    localparam int TXN = serpario_pkg::txn_cycles(16, 2);

`ifdef SERPARIO_CHANGE_IRQ_EN
    localparam logic IRQ_EN = 1'b1;
`else
    localparam logic IRQ_EN = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        reset = 1'b1;
    logic        start_i = 1'b0;
    logic        irq_ack_i = 1'b0;
    logic [15:0] out_data_i = '0;
    logic        busy_o, done_o, irq_o, ser_in_i, ser_out_o, sh_clk_o, store_o, out_en_o;
    logic [15:0] in_data_o;

    serpario_chain #(.WIDTH(16), .CLK_DIV(2), .REFRESH(200)) dut (
        .clk_i      (clk_i),
        .reset      (reset),
        .out_data_i (out_data_i),
        .start_i    (start_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .in_data_o  (in_data_o),
        .irq_o      (irq_o),
        .irq_ack_i  (irq_ack_i),
        .ser_in_i   (ser_in_i),
        .ser_out_o  (ser_out_o),
        .sh_clk_o   (sh_clk_o),
        .store_o    (store_o),
        .out_en_o   (out_en_o)
    );

    always #5 clk_i = ~clk_i;

    // '165 chain: parallel load while store low, shift toward Q_H on sh_clk rise.
    logic [15:0] pins = 16'hBEEF;
    logic [15:0] sr165 = '0;
    logic        sh_seen = 1'b0;
    always @(posedge clk_i) begin
        if (!store_o) sr165 <= pins;
        else if (sh_clk_o && !sh_seen) sr165 <= {sr165[14:0], 1'b0};
        sh_seen <= sh_clk_o;
    end
    assign ser_in_i = sr165[15];

    int checks = 0, failures = 0;
    int cyc = 0, t0 = 0;
    int done_rel, done_cnt, rises, last_rise, store_rise;
    logic [15:0] bits, done_data;
    logic sh_prev = 1'b0, st_prev = 1'b1;
    logic busy1, busy70, busy80;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk_i);
        cyc++;
        if (sh_clk_o && !sh_prev) begin
            bits = {bits[14:0], ser_out_o};
            rises++;
            last_rise = cyc;
        end
        if (store_o && !st_prev) store_rise = cyc;
        if (done_o) begin
            done_cnt++;
            if (done_rel < 0) begin
                done_rel  = cyc - t0;
                done_data = in_data_o;
            end
        end
        sh_prev = sh_clk_o;
        st_prev = store_o;
    endtask

    task automatic reset_values(input string tag);
        check({tag, "_busy"},    32'(busy_o),    32'd1);
        check({tag, "_done"},    32'(done_o),    32'd0);
        check({tag, "_in_data"}, 32'(in_data_o), 32'd0);
        check({tag, "_irq"},     32'(irq_o),     32'd0);
        check({tag, "_sh_clk"},  32'(sh_clk_o),  32'd0);
        check({tag, "_ser_out"}, 32'(ser_out_o), 32'd0);
        check({tag, "_store"},   32'(store_o),   32'd1);
        check({tag, "_out_en"},  32'(out_en_o),  32'd1);
    endtask

    // Called at a negedge with reset high; the next posedge is cycle 0.
    task automatic init_seq(input string tag);
        logic [3:0] st;
        logic b3, b4, dn, oe;
        st = '0; b3 = 1'b0; b4 = 1'b1; dn = 1'b0; oe = 1'b1;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (i < 4) st[i] = store_o;
            if (i == 3) b3 = busy_o;
            if (i == 4) b4 = busy_o;
            dn = dn | done_o;
            oe = oe & out_en_o;
        end
        check({tag, "_store_seq"}, 32'(st), 32'h0000_000C);
        check({tag, "_busy_c3"},   32'(b3), 32'd1);
        check({tag, "_busy_c4"},   32'(b4), 32'd0);
        check({tag, "_no_done"},   32'(dn), 32'd0);
        check({tag, "_out_en"},    32'(oe), 32'd1);
    endtask

    // Current cycle (IDLE) is cycle 0; runs to cycle TXN+11.
    task automatic txn(input logic [15:0] data, input int drop_at, input int pin_at,
                       input logic [15:0] pin_val, input int ack_at);
        int rel;
        out_data_i = data;
        start_i    = 1'b1;
        t0 = cyc;
        done_rel = -1; done_cnt = 0; rises = 0; bits = '0;
        last_rise = 0; store_rise = 0; done_data = '0;
        busy1 = 1'b0; busy70 = 1'b1; busy80 = 1'b1;
        rel = 0;
        while (rel < TXN + 11) begin
            step();
            rel = cyc - t0;
            start_i   = (rel == drop_at);
            irq_ack_i = (rel == ack_at);
            if (rel == pin_at) pins = pin_val;
            if (rel == 1)  busy1  = busy_o;
            if (rel == 70) busy70 = busy_o;
            if (rel == 80) busy80 = busy_o;
        end
        start_i   = 1'b0;
        irq_ack_i = 1'b0;
    endtask

    initial begin
        repeat (3) step();
        reset_values("rst0");
        init_seq("init0");
        pins = 16'h1234;
        step();
        step();

        txn(16'hA5C3, -1, -1, 16'h0000, -1);
        check("t1_done_cycle",  32'(done_rel), 32'd69);
        check("t1_done_count",  32'(done_cnt), 32'd1);
        check("t1_bits",        32'(bits), 32'h0000_A5C3);
        check("t1_rises",       32'(rises), 32'd16);
        check("t1_store_rise",  32'(store_rise - t0), 32'd67);
        check("t1_busy_c1",     32'(busy1), 32'd1);
        check("t1_busy_c70",    32'(busy70), 32'd0);
        check("t1_out_en",      32'(out_en_o), 32'd0);
        check("t1_in_data",     32'(done_data), 32'h0000_BEEF);
        check("t1_irq",         32'(irq_o), 32'd0);

        txn(16'h0F0F, 10, -1, 16'h0000, -1);
        check("t2_done_cycle",  32'(done_rel), 32'd69);
        check("t2_done_count",  32'(done_cnt), 32'd1);
        check("t2_no_queue",    32'(busy80), 32'd0);
        check("t2_bits",        32'(bits), 32'h0000_0F0F);
        check("t2_in_data",     32'(done_data), 32'h0000_1234);
        check("t2_irq",         32'(irq_o), 32'(IRQ_EN));

        irq_ack_i = 1'b1;
        step();
        irq_ack_i = 1'b0;
        check("ack_clears",     32'(irq_o), 32'd0);

        txn(16'hA5C3, -1, 20, 16'h00FF, -1);
        check("t3_in_data_lag", 32'(done_data), 32'h0000_1234);
        check("t3_irq_nochg",   32'(irq_o), 32'd0);

        txn(16'hA5C3, -1, -1, 16'h0000, 68);
        check("t4_in_data",     32'(done_data), 32'h0000_00FF);
        check("t4_bits",        32'(bits), 32'h0000_A5C3);
        check("t4_irq_set_wins", 32'(irq_o), 32'(IRQ_EN));

        // Refresh: done at t0+69, 200 idle cycles, accepted at t0+269.
        rises = 0;
        bits  = '0;
        while (cyc - t0 < 269) step();
        check("ref_idle_c200",  32'(busy_o), 32'd0);
        step();
        check("ref_busy",       32'(busy_o), 32'd1);
        while (cyc - t0 < 299) step();
        check("ref_rises_c30",  32'(rises), 32'd7);
        check("ref_bits_c30",   32'(bits[6:0]), 32'h0000_0052);
        check("ref_out_en",     32'(out_en_o), 32'd0);
        check("ref_in_data",    32'(in_data_o), 32'h0000_00FF);

        reset = 1'b1;
        step();
        reset_values("rst1");
        step();
        init_seq("init1");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
